// File: rtl/jvm_pkg.sv
// Shared opcodes, FSM encoding and instruction field positions for the JVM decoder slice.
package jvm_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_M1 = 8'h02;
    localparam logic [7:0] OP_ICONST_0  = 8'h03;
    localparam logic [7:0] OP_ICONST_1  = 8'h04;
    localparam logic [7:0] OP_ICONST_2  = 8'h05;
    localparam logic [7:0] OP_ICONST_3  = 8'h06;
    localparam logic [7:0] OP_ICONST_4  = 8'h07;
    localparam logic [7:0] OP_ICONST_5  = 8'h08;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_POP       = 8'h57;
    localparam logic [7:0] OP_DUP       = 8'h59;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_ISUB      = 8'h64;
    localparam logic [7:0] OP_IMUL      = 8'h68;
    localparam logic [7:0] OP_I2B       = 8'h91;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;

    // Opcode classes; every instruction maps to exactly one.
    typedef enum logic [3:0] {
        K_NOP, K_PUSH, K_POP, K_DUP, K_ADD, K_SUB, K_MUL, K_I2B, K_ILL
    } kind_t;

endpackage

// File: rtl/jvm_operand_stack.sv
// LIFO register-array operand stack; pure storage, the caller guarantees legal operations.
module jvm_operand_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       pop2_push,
    input  logic                       replace_top,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          top,
    output logic [DATA_W-1:0]          second,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [IW-1:0] i_new, i_top, i_sec;

    // Index arithmetic wraps mod DEPTH, so a full stack still addresses its top correctly.
    assign i_new  = count[IW-1:0];
    assign i_top  = i_new - IW'(1);
    assign i_sec  = i_new - IW'(2);
    assign top    = (count != '0)      ? mem[i_top] : '0;
    assign second = (count >= CW'(2))  ? mem[i_sec] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            count <= '0;
        end else if (push) begin
            mem[i_new] <= wdata;
            count      <= count + CW'(1);
        end else if (pop) begin
            count <= count - CW'(1);
        end else if (pop2_push) begin
            mem[i_sec] <= wdata;
            count      <= count - CW'(1);
        end else if (replace_top) begin
            mem[i_top] <= wdata;
        end
    end

endmodule

// File: rtl/jvm_bytecode_decoder.sv
// Fixed-latency JVM integer-subset decoder/executor; define JVM_IMUL_EN to support imul (0x68).
module jvm_bytecode_decoder
    import jvm_pkg::*;
#(
    parameter int WIDTH_IN    = 16,
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_for_decoder,
    input  logic [WIDTH_IN-1:0]            data_for_decoder,
    output logic                           ready_from_decoder,
    output logic                           done,
    output logic [DATA_W-1:0]              stack_top,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           illegal_opcode,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    state_t state, state_next;
    kind_t  kind, kind_d;
    logic [WIDTH_IN-1:0] instr;
    logic [7:0]          opcode, imm;
    logic                under, over, under_d, over_d, fault;
    logic [DATA_W-1:0]   result, result_d, second;
    logic                push, pop, pop2_push, replace_top;

    assign opcode = instr[OPC_HI:OPC_LO];
    assign imm    = instr[IMM_HI:IMM_LO];
    assign fault  = under | over;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_for_decoder) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_from_decoder = (state == IDLE);
        done               = (state == WRITE);
        push               = 1'b0;
        pop                = 1'b0;
        pop2_push          = 1'b0;
        replace_top        = 1'b0;
        if (state == WRITE && !fault) begin
            push        = (kind == K_PUSH) || (kind == K_DUP);
            pop         = (kind == K_POP);
            pop2_push   = (kind == K_ADD) || (kind == K_SUB) || (kind == K_MUL);
            replace_top = (kind == K_I2B);
        end
    end

    always_comb begin
        kind_d = K_ILL;
        case (opcode) inside
            OP_NOP:                      kind_d = K_NOP;
            [OP_ICONST_M1:OP_ICONST_5]:  kind_d = K_PUSH;
            OP_BIPUSH:                   kind_d = K_PUSH;
            OP_POP:                      kind_d = K_POP;
            OP_DUP:                      kind_d = K_DUP;
            OP_IADD:                     kind_d = K_ADD;
            OP_ISUB:                     kind_d = K_SUB;
`ifdef JVM_IMUL_EN
            OP_IMUL:                     kind_d = K_MUL;
`endif
            OP_I2B:                      kind_d = K_I2B;
            default:                     kind_d = K_ILL;
        endcase
    end

    // Preconditions are judged against the count seen in DECODE; no other instruction is in flight.
    always_comb begin
        under_d = 1'b0;
        over_d  = 1'b0;
        case (kind_d)
            K_POP, K_I2B:        under_d = (stack_count == '0);
            K_ADD, K_SUB, K_MUL: under_d = (stack_count < CW'(2));
            K_DUP: begin
                under_d = (stack_count == '0);
                over_d  = (stack_count == FULL);
            end
            K_PUSH:              over_d  = (stack_count == FULL);
            default: ;
        endcase
    end

    always_comb begin
        result_d = '0;
        case (kind)
            K_PUSH:  result_d = (opcode == OP_BIPUSH) ? {{(DATA_W-8){imm[7]}}, imm}
                                                      : DATA_W'(opcode) - DATA_W'(3);
            K_DUP:   result_d = stack_top;
            K_ADD:   result_d = second + stack_top;
            K_SUB:   result_d = second - stack_top;
`ifdef JVM_IMUL_EN
            K_MUL:   result_d = second * stack_top;
`endif
            K_I2B:   result_d = {{(DATA_W-8){stack_top[7]}}, stack_top[7:0]};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr           <= '0;
            kind            <= K_NOP;
            under           <= 1'b0;
            over            <= 1'b0;
            result          <= '0;
            illegal_opcode  <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (state == IDLE && start_for_decoder) instr <= data_for_decoder;
            if (state == DECODE) begin
                kind  <= kind_d;
                under <= under_d;
                over  <= over_d;
            end
            if (state == EXEC) result <= result_d;
            if (state == WRITE) begin
                illegal_opcode  <= illegal_opcode  | (kind == K_ILL);
                stack_overflow  <= stack_overflow  | over;
                stack_underflow <= stack_underflow | under;
            end
        end
    end

    jvm_operand_stack #(.DATA_W(DATA_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .pop2_push   (pop2_push),
        .replace_top (replace_top),
        .wdata       (result),
        .top         (stack_top),
        .second      (second),
        .count       (stack_count)
    );

endmodule

// File: tb/tb_jvm_bytecode_decoder.sv
// Scoreboard bench for jvm_bytecode_decoder; expectations come from a behavioural stack model.
module tb_jvm_bytecode_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        ready, done, ill, ovf, und;
    logic [31:0] top;
    logic [3:0]  cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int accepts = 0;
    bit busy = 0;
    bit pending = 0;

    typedef struct {
        logic [31:0] top;
        int          cnt;
        bit          ill, ovf, und;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mstk[$];
    bit          mill = 0, movf = 0, mund = 0;

    jvm_bytecode_decoder dut (
        .clk                (clk),
        .reset              (reset),
        .start_for_decoder  (start),
        .data_for_decoder   (data),
        .ready_from_decoder (ready),
        .done               (done),
        .stack_top          (top),
        .stack_count        (cnt),
        .illegal_opcode     (ill),
        .stack_overflow     (ovf),
        .stack_underflow    (und)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic model_apply(input logic [15:0] w);
        logic [7:0]  op;
        logic [31:0] a, b;
        int          n;
        exp_t        e;
        op = w[15:8];
        n  = mstk.size();
        case (op) inside
            8'h00: ;
            [8'h02:8'h08]: if (n == 8) movf = 1; else mstk.push_back(32'(int'(op) - 3));
            8'h10: if (n == 8) movf = 1; else mstk.push_back({{24{w[7]}}, w[7:0]});
            8'h57: if (n < 1) mund = 1; else void'(mstk.pop_back());
            8'h59: if (n < 1) mund = 1; else if (n == 8) movf = 1; else mstk.push_back(mstk[n-1]);
            8'h60, 8'h64
`ifdef JVM_IMUL_EN
            , 8'h68
`endif
            : if (n < 2) mund = 1;
              else begin
                  b = mstk.pop_back();
                  a = mstk.pop_back();
                  mstk.push_back(op == 8'h60 ? a + b : op == 8'h64 ? a - b : a * b);
              end
            8'h91: if (n < 1) mund = 1; else mstk[n-1] = {{24{mstk[n-1][7]}}, mstk[n-1][7:0]};
            default: mill = 1;
        endcase
        e.top = (mstk.size() != 0) ? mstk[mstk.size()-1] : 32'h0;
        e.cnt = mstk.size();
        e.ill = mill;
        e.ovf = movf;
        e.und = mund;
        sb.push_back(e);
    endtask

    // Monitor: inputs change just after posedge, so negedge sees stable values.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            sb.delete();
            mstk.delete();
            mill = 0; movf = 0; mund = 0;
            busy = 0; pending = 0;
        end else begin
            if (pending) begin
                e = sb.pop_front();
                chk("sb_top", top, e.top);
                chk("sb_count", 32'(cnt), 32'(e.cnt));
                chk("sb_illegal", 32'(ill), 32'(e.ill));
                chk("sb_overflow", 32'(ovf), 32'(e.ovf));
                chk("sb_underflow", 32'(und), 32'(e.und));
                chk("ready_back", 32'(ready), 1);
                pending = 0;
                busy = 0;
            end
            if (busy && (cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= 3)
                chk("ready_low", 32'(ready), 0);
            if (done) begin
                chk("done_expected", 32'(sb.size() != 0), 1);
                chk("done_latency", 32'(cyc - acc_cyc), 3);
                pending = (sb.size() != 0);
            end
            if (start && ready) begin
                model_apply(data);
                acc_cyc = cyc;
                busy = 1;
                accepts++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((!ready || busy || pending) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 32'(ready && !busy && !pending), 1);
    endtask

    task automatic send(input logic [15:0] w);
        wait_idle();
        start = 1'b1;
        data  = w;
        @(posedge clk); #1;
        start = 1'b0;
        data  = 16'h5A5A;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        int a0, n;
        reset_dut();
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_top", top, 0);
        chk("rst_flags", {29'b0, ill, ovf, und}, 0);
        @(posedge clk); #1;

        // iconst_0, iconst_1 (operand noise ignored), iadd
        send(16'h0300); send(16'h04A5); send(16'h6000);
        wait_idle();
        chk("add_top", top, 32'h1);
        chk("add_count", 32'(cnt), 1);

        reset_dut();
        send(16'h1080); send(16'h9100); send(16'h107F);
        wait_idle();
        chk("bipush_top", top, 32'h0000007F);
        chk("bipush_count", 32'(cnt), 2);

        reset_dut();
        send(16'h6000); send(16'h6F00);
        wait_idle();
        chk("under_flag", 32'(und), 1);
        chk("ill_flag", 32'(ill), 1);
        chk("fault_count", 32'(cnt), 0);

        // level-held start, nine pushes into an 8-deep stack
        reset_dut();
        wait_idle();
        a0 = accepts;
        n = 0;
        start = 1'b1;
        data  = 16'h0800;
        while ((accepts - a0) < 9 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        chk("held_accepts", 32'(accepts - a0), 9);
        chk("full_count", 32'(cnt), 8);
        chk("full_top", top, 32'h5);
        chk("full_ovf", 32'(ovf), 1);
        chk("full_und", 32'(und), 0);

        // reset during EXEC aborts the instruction
        reset_dut();
        wait_idle();
        start = 1'b1;
        data  = 16'h0300;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_count", 32'(cnt), 0);
        chk("abort_ready", 32'(ready), 1);
        repeat (4) begin
            chk("abort_no_done", 32'(done), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        reset_dut();
        send(16'h0300); send(16'h0400); send(16'h6800);
        wait_idle();
`ifdef JVM_IMUL_EN
        chk("imul_top", top, 32'h0);
        chk("imul_count", 32'(cnt), 1);
        chk("imul_ill", 32'(ill), 0);
`else
        chk("imul_ill", 32'(ill), 1);
        chk("imul_count", 32'(cnt), 2);
        chk("imul_top", top, 32'h1);
`endif

        // mixed sequence: dup, isub, pop, i2b on a non-negative value
        reset_dut();
        send(16'h10F0); send(16'h5900); send(16'h0700); send(16'h6400);
        send(16'h5700); send(16'h1023); send(16'h9100); send(16'h5700);
        send(16'h5700); send(16'h5700);
        wait_idle();
        chk("mix_count", 32'(cnt), 0);
        chk("mix_top", top, 32'h0);
        chk("mix_und", 32'(und), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
